ham_enc_tx: RTL and testbench

Streaming Hamming(7,4) encoder and serial transmitter. It accepts 4-bit data nibbles over a valid/ready handshake and computes the 7-bit codeword. It shifts the codeword out MSB-first, one bit per enabled cycle, with frame delimiters. It sits on the transmit side of a link whose receive end runs the existing 7-bit Hamming syndrome decoder, and produces codewords in exactly the bit layout that decoder expects.

---
 rtl/ham_pkg.sv | 28 ++
 rtl/ham74_enc.sv | 21 ++
 rtl/ham_enc_tx.sv | 105 ++++++++++
 tb/tb_ham_enc_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: widths, transmitter state encoding and the
// parity function also used by the receive-side syndrome checker. Honours HAM_SECDED_EN.
`timescale 1ns/1ps
package ham_pkg;

    localparam int HAM_DATA_W  = 4;
    localparam int HAM_CW_BASE = 7;

`ifdef HAM_SECDED_EN
    localparam int HAM_CW = HAM_CW_BASE + 1;
`else
    localparam int HAM_CW = HAM_CW_BASE;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ham_state_t;

    // Returns {c2, c1, c0} for data = {c6, c5, c4, c3}.
    function automatic logic [2:0] ham74_parity(input logic [HAM_DATA_W-1:0] data);
        return {data[3] ^ data[2] ^ data[0],
                data[3] ^ data[1] ^ data[0],
                data[2] ^ data[1] ^ data[0]};
    endfunction

endpackage

// File: rtl/ham74_enc.sv
// Combinational nibble-to-codeword encoder. With HAM_SECDED_EN defined an even
// overall parity bit is appended as the LSB.
`timescale 1ns/1ps
module ham74_enc
    import ham_pkg::*;
(
    input  logic [HAM_DATA_W-1:0] i_data,
    output logic [HAM_CW-1:0]     o_code
);

    logic [HAM_CW_BASE-1:0] w_cw7;

    assign w_cw7 = {i_data, ham74_parity(i_data)};

`ifdef HAM_SECDED_EN
    assign o_code = {w_cw7, ^w_cw7};
`else
    assign o_code = w_cw7;
`endif

endmodule

// File: rtl/ham_enc_tx.sv
// Streaming Hamming encoder and MSB-first serial transmitter with frame markers
// and an optional inter-frame idle gap. Frame width set by HAM_SECDED_EN.
`timescale 1ns/1ps
module ham_enc_tx
    import ham_pkg::*;
#(
    parameter int IDLE_GAP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [HAM_DATA_W-1:0] in_data,
    output logic                  in_ready,
    input  logic                  tx_en,
    output logic                  ser_data,
    output logic                  ser_valid,
    output logic                  ser_first,
    output logic                  ser_last,
    output logic [HAM_CW-1:0]     code_out,
    output logic                  busy
);

    localparam int                CNT_W    = $clog2(HAM_CW);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(HAM_CW - 1);
    localparam bit                NO_GAP   = (IDLE_GAP == 0);
    localparam logic [3:0]        GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

    ham_state_t          r_state;
    logic [HAM_CW-1:0]   r_shreg;
    logic [HAM_CW-1:0]   r_code;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [3:0]          r_gap_cnt;

    logic [HAM_CW-1:0]   w_code;
    logic                w_in_shift;
    logic                w_on_last;
    logic                w_accept;

    ham74_enc u_enc (
        .i_data (in_data),
        .o_code (w_code)
    );

    assign w_in_shift = (r_state == SHIFT);
    assign w_on_last  = w_in_shift && (r_bit_cnt == LAST_BIT);
    assign w_accept   = in_valid && in_ready;

    // Without a gap the next nibble may be taken while the last bit leaves.
    assign in_ready  = !rst && ((r_state == IDLE) || (NO_GAP && w_on_last && tx_en));
    assign ser_valid = w_in_shift && tx_en;
    assign ser_data  = r_shreg[HAM_CW-1];
    assign ser_first = ser_valid && (r_bit_cnt == '0);
    assign ser_last  = ser_valid && (r_bit_cnt == LAST_BIT);
    assign code_out  = r_code;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_code    <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_code;
                        r_code    <= w_code;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tx_en) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            if (w_accept) begin
                                r_shreg   <= w_code;
                                r_code    <= w_code;
                                r_bit_cnt <= '0;
                            end else begin
                                r_shreg   <= {r_shreg[HAM_CW-2:0], 1'b0};
                                r_bit_cnt <= '0;
                                r_gap_cnt <= '0;
                                r_state   <= NO_GAP ? IDLE : GAP;
                            end
                        end else begin
                            r_shreg   <= {r_shreg[HAM_CW-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ham_enc_tx.sv
// Self-checking bench for ham_enc_tx: directed timing steps plus randomized traffic
// scored against a frame-level reference model. Works with or without HAM_SECDED_EN.
`timescale 1ns/1ps
module tb_ham_enc_tx;

`ifdef HAM_SECDED_EN
    localparam int CW = 8;
    localparam logic [7:0] EXP_B = 8'hB4;
    localparam logic [7:0] EXP_F = 8'hFF;
`else
    localparam int CW = 7;
    localparam logic [7:0] EXP_B = 8'h5A;
    localparam logic [7:0] EXP_F = 8'h7F;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          v0, r0, t0, sd0, sv0, sf0, sl0, b0;
    logic [3:0]    d0;
    logic [CW-1:0] co0;
    logic          v3, r3, t3, sd3, sv3, sf3, sl3, b3;
    logic [3:0]    d3;
    logic [CW-1:0] co3;

    ham_enc_tx #(.IDLE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0), .tx_en(t0),
        .ser_data(sd0), .ser_valid(sv0), .ser_first(sf0), .ser_last(sl0),
        .code_out(co0), .busy(b0)
    );

    ham_enc_tx #(.IDLE_GAP(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3), .tx_en(t3),
        .ser_data(sd3), .ser_valid(sv3), .ser_first(sf3), .ser_last(sl3),
        .code_out(co3), .busy(b3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: parity groups as data-bit masks over {c6,c5,c4,c3}.
    function automatic logic [7:0] model_cw(input logic [3:0] d);
        logic [6:0] c;
        c[6:3] = d;
        c[2] = ($countones(d & 4'b1101) % 2) == 1;
        c[1] = ($countones(d & 4'b1011) % 2) == 1;
        c[0] = ($countones(d & 4'b0111) % 2) == 1;
        if (CW == 8) return {c, (($countones(c) % 2) == 1)};
        return {1'b0, c};
    endfunction

    logic [7:0] exp_q[$];
    logic [7:0] mon_bits = '0;
    int         mon_n = 0;
    int         mon_frames = 0;

    // Frame-level scoreboard on the zero-gap instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (v0 && r0) exp_q.push_back(model_cw(d0));
            if (sv0) begin
                if (sf0) begin
                    mon_n = 0;
                    mon_bits = '0;
                    chk("mon_frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("mon_code_out", co0, exp_q[0]);
                end
                mon_bits = {mon_bits[6:0], sd0};
                mon_n++;
                if (sl0) begin
                    chk("mon_frame_len", mon_n, CW);
                    chk("mon_frame_end_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("mon_frame_bits", mon_bits, exp_q.pop_front());
                    mon_frames++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] eb;
        logic [7:0] ef;
        logic [7:0] er;
        logic [3:0] dr;
        int n;
        eb = EXP_B;
        ef = EXP_F;
        v0 = 0; d0 = 0; t0 = 0;
        v3 = 0; d3 = 0; t3 = 0;

        // Reset state, checked while reset is asserted and after release.
        #1 rst = 1;
        #1;
        chk("rst_in_ready", r0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_code_out", co0, 0);
        chk("rst_ser_valid", sv0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("idle_in_ready", r0, 1);
        chk("idle_busy", b0, 0);
        chk("idle_ser_data", sd0, 0);
        chk("idle_ser_first", sf0, 0);
        chk("idle_ser_last", sl0, 0);
        chk("idle_code_out", co0, 0);

        // Single frame of 4'b1011 with tx_en held high.
        next_cycle();
        v0 = 1; d0 = 4'b1011; t0 = 1;
        @(negedge clk);
        chk("t1_ready", r0, 1);
        next_cycle();
        v0 = 0;
        for (int i = 0; i < CW; i++) begin
            @(negedge clk);
            chk("t1_valid", sv0, 1);
            chk("t1_bit", sd0, eb[CW-1-i]);
            chk("t1_first", sf0, (i == 0));
            chk("t1_last", sl0, (i == CW - 1));
            chk("t1_code_out", co0, eb);
            next_cycle();
        end
        @(negedge clk);
        chk("t1_after_valid", sv0, 0);
        chk("t1_after_busy", b0, 0);
        chk("t1_code_hold", co0, eb);

        // Back-to-back 4'h0 then 4'hF with no bubble.
        next_cycle();
        v0 = 1; d0 = 4'h0;
        @(negedge clk);
        next_cycle();
        v0 = 0;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) begin v0 = 1; d0 = 4'hF; end
            @(negedge clk);
            chk("t2_zero_bit", sd0, 0);
            chk("t2_zero_valid", sv0, 1);
            if (i == CW - 1) chk("t2_ready_on_last", r0, 1);
            next_cycle();
            v0 = 0;
        end
        for (int j = 0; j < CW; j++) begin
            @(negedge clk);
            chk("t2_no_bubble", sv0, 1);
            chk("t2_one_bit", sd0, 1);
            chk("t2_first", sf0, (j == 0));
            chk("t2_code_out", co0, ef);
            next_cycle();
        end

        // Pause for 3 cycles after bit 2 of 4'b1011.
        v0 = 1; d0 = 4'b1011;
        @(negedge clk);
        next_cycle();
        v0 = 0;
        for (int i = 0; i < CW; i++) begin
            if (i == 3) begin
                t0 = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_pause_valid", sv0, 0);
                    chk("t3_pause_hold", sd0, eb[CW-4]);
                    chk("t3_pause_last", sl0, 0);
                    chk("t3_pause_busy", b0, 1);
                    next_cycle();
                end
                t0 = 1;
            end
            @(negedge clk);
            chk("t3_bit", sd0, eb[CW-1-i]);
            chk("t3_last", sl0, (i == CW - 1));
            next_cycle();
        end

        // Asynchronous reset in the middle of a frame.
        v0 = 1; d0 = 4'b1011;
        @(negedge clk);
        next_cycle();
        v0 = 0;
        repeat (4) begin @(negedge clk); next_cycle(); end
        @(negedge clk);
        chk("t4_mid_valid", sv0, 1);
        #2 rst = 1;
        #1;
        chk("t4_rst_data", sd0, 0);
        chk("t4_rst_valid", sv0, 0);
        chk("t4_rst_first", sf0, 0);
        chk("t4_rst_last", sl0, 0);
        chk("t4_rst_busy", b0, 0);
        chk("t4_rst_ready", r0, 0);
        chk("t4_rst_code", co0, 0);
        exp_q.delete();
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("t4_post_ready", r0, 1);
        chk("t4_post_busy", b0, 0);
        next_cycle();
        dr = 4'($urandom_range(0, 15));
        er = model_cw(dr);
        v0 = 1; d0 = dr;
        @(negedge clk);
        next_cycle();
        v0 = 0;
        @(negedge clk);
        chk("t4_clean_first", sf0, 1);
        chk("t4_clean_msb", sd0, er[CW-1]);
        next_cycle();
        repeat (CW) begin @(negedge clk); next_cycle(); end

        // IDLE_GAP=3 instance with in_valid held high.
        v3 = 1; d3 = 4'b1011; t3 = 1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sl3) break;
            n++;
            next_cycle();
        end
        chk("t5_last_seen", sl3, 1);
        chk("t5_ready_on_last", r3, 0);
        chk("t5_code_out", co3, eb);
        for (int g = 0; g < 3; g++) begin
            next_cycle();
            @(negedge clk);
            chk("t5_gap_ready", r3, 0);
            chk("t5_gap_busy", b3, 1);
            chk("t5_gap_valid", sv3, 0);
        end
        next_cycle();
        @(negedge clk);
        chk("t5_idle_ready", r3, 1);
        chk("t5_idle_busy", b3, 0);
        next_cycle();
        @(negedge clk);
        chk("t5_next_first", sf3, 1);
        chk("t5_next_valid", sv3, 1);
        v3 = 0;

        // Randomized traffic on the zero-gap instance, scored by the monitor.
        next_cycle();
        for (int c = 0; c < 400; c++) begin
            v0 = 1'($urandom_range(0, 1));
            d0 = 4'($urandom_range(0, 15));
            t0 = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        v0 = 0; t0 = 1;
        repeat (2 * CW + 2) next_cycle();
        chk("rand_queue_drained", exp_q.size(), 0);
        chk("rand_frames_seen", 32'(mon_frames > 20), 1);
        chk("rand_idle_at_end", b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
